lcd_line_sched: RTL and testbench
=================================

# lcd_line_sched

Bus owner and scheduler for the QC12864B (ST7920) 8-bit parallel LCD port. Runs power-up and the basic-instruction init sequence once, then shares the display between up to four line requesters with round-robin arbitration. Each grant rewrites one full 16-byte display line: one DDRAM address command plus 16 data bytes. The block replaces free-running fixed-tick LCD drivers: every byte is paced by the cycle counters below, not by a derived slow clock.

## Interface
- `T_POWERUP`, 2_000_000: cycles of wait after reset before the first command (40 ms at 50 MHz).
- `T_BYTE`, 3_600: cycles per command or data byte, measured from setup to the next setup (72 µs).
- `T_CLEAR`, 80_000: cycles allotted to the clear command 0x01 (1.6 ms).
- `T_EN`, 25: EN high width in cycles (500 ns); must satisfy T_EN + 2 < T_BYTE.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  req[i]=1 requests a rewrite of LCD line i.
- `rd_data`  in  8  byte for the granted line at `rd_idx`; combinational from the requester.
- `gnt`  out  4  one-hot grant, or all zero.
- `rd_idx`  out  4  byte index 0..15 within the granted line.
- `done`  out  4  one-cycle pulse when line i has been fully written.
- `busy`  out  1  high whenever the block is not in IDLE.
- `init_done`  out  1  high after the init sequence completes; stays high until reset.
- `RS`, `RW`, `PSB`, `EN`  out  1 each  LCD control lines.
- `DB`  out  8  LCD data bus.

## Operation
- Fixed outputs: RW=0 (write only) and PSB=1 (parallel mode).
- States:
  - PWRUP: wait T_POWERUP cycles, then go to INIT.
  - INIT: send commands 0x30, 0x30, 0x0C, 0x01, 0x06 with RS=0. Command 0x01 uses T_CLEAR; the others use T_BYTE. When the last one finishes, set init_done and go to IDLE.
  - IDLE: wait for any req bit.
  - ARB: pick the winner.
  - ADDR: send the line address with RS=0.
  - DATA: send 16 bytes with RS=1.
  - DONE: pulse done, then return to IDLE.
- Line addresses: line 0=0x80, line 1=0x90, line 2=0x88, line 3=0x98.
- Arbitration:
  - Round-robin pointer `ptr`, reset to 0.
  - In ARB, the winner is the first index at or after ptr, going upward and wrapping, whose req bit is set.
  - In DONE, ptr becomes winner+1 mod 4.
  - req is sampled only in IDLE/ARB. Any requests that arrive during INIT are held off and served after it completes.
- Grant rules:
  - gnt[w] is set on entry to ADDR and cleared on entry to DONE.
  - Dropping req while granted does not abort the line; it is written to completion.
  - A req held continuously is re-granted only after the other pending requesters have had their turn.
- Byte engine: counter `bc` runs from 0 to L-1, where L is T_BYTE or T_CLEAR.
  - bc=0: DB and RS are loaded, using rd_data for data bytes.
  - bc=1 to T_EN: EN=1.
  - Otherwise EN=0.
  - bc=L-1: the byte is complete.
- Data byte indexing: rd_idx is set to k on the cycle the previous byte (ADDR, or data k-1) completes. rd_data is sampled at the next bc=0, so rd_idx is stable for at least one cycle before it is sampled.
- DB and RS hold their values between bytes.

## Timing
- Reset values:
  - EN=0 (forced asynchronously by rst_n, so EN never glitches high during reset).
  - DB=0x00, RS=0, gnt=0, done=0, rd_idx=0.
  - busy=1, init_done=0.
  - State PWRUP, ptr=0.
- Init duration: T_POWERUP + 4·T_BYTE + T_CLEAR + 1 cycles from reset release to init_done=1.
- Line write: 17·T_BYTE cycles from the gnt rising edge to the last byte completing. done pulses on the following cycle, at the same edge gnt falls.
- IDLE → ARB → ADDR takes 2 cycles after req is seen. busy drops in the cycle after DONE.
- Setup and hold: DB/RS change exactly 1 cycle before EN rises. They remain stable for at least T_BYTE−T_EN−1 cycles after EN falls.
- Reset mid-byte: the sequence restarts from PWRUP and any in-flight line is discarded with no done pulse.

## Structure
- Package `lcd_pkg` holds:
  - the command constants RE_BASIC=0x30, DISP_ON=0x0C, CLEAR=0x01, ENTRY=0x06;
  - the four line-address constants;
  - the state enum.
- Sub-module `lcd_byte_wr`, the byte engine:
  - Inputs: start, rs, data, long_cmd.
  - Outputs: RS, DB, EN, ready.
  - Parameterised by T_BYTE, T_CLEAR, T_EN.
- The scheduler FSM and arbiter live in the top module.

## Test plan
Bench parameters: T_POWERUP=100, T_BYTE=40, T_CLEAR=200, T_EN=5.
- Init: release reset → the EN-rising DB sequence is 0x30, 0x30, 0x0C, 0x01, 0x06 with RS=0. The gap after 0x01 is 200 cycles; init_done rises at cycle 461.
- Single line: pulse req=4'b0100 after init → gnt=0100. An address byte 0x88 with RS=0 is followed by 16 bytes equal to rd_data for rd_idx 0..15 with RS=1. done[2] pulses 680 cycles after gnt rises.
- Fairness: hold req=4'b1111 → grants come in order 0, 1, 2, 3, 0, with no line repeated before all four are served.
- Request during init: req=0001 asserted at cycle 10 → gnt stays 0 until init_done, then line 0 is written.
- Drop request: req[1] deasserted mid-DATA → all 16 bytes are still sent and done[1] pulses.
- Reset mid-line: assert rst_n low at data byte 7 → EN=0 immediately and no done pulse. After release the init sequence repeats exactly.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and small lookups for the ST7920 line scheduler.
package lcd_pkg;

  localparam logic [7:0] RE_BASIC = 8'h30;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;

  localparam logic [7:0] LINE0_ADDR = 8'h80;
  localparam logic [7:0] LINE1_ADDR = 8'h90;
  localparam logic [7:0] LINE2_ADDR = 8'h88;
  localparam logic [7:0] LINE3_ADDR = 8'h98;

  localparam int N_INIT_CMDS  = 5;
  localparam int LINE_BYTES   = 16;
  localparam int CLEAR_CMD_IX = 3;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] ix);
    case (ix)
      3'd0, 3'd1: init_cmd = RE_BASIC;
      3'd2:       init_cmd = DISP_ON;
      3'd3:       init_cmd = CLEAR;
      default:    init_cmd = ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] line_addr(input logic [1:0] line);
    case (line)
      2'd0:    line_addr = LINE0_ADDR;
      2'd1:    line_addr = LINE1_ADDR;
      2'd2:    line_addr = LINE2_ADDR;
      default: line_addr = LINE3_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_wr.sv
// Byte engine: presents DB/RS at bc=0, pulses EN for bc=1..T_EN, completes at bc=L-1.
// Accepts a new byte in its completion cycle so consecutive bytes run back to back.
module lcd_byte_wr #(
  parameter int T_BYTE  = 3_600,
  parameter int T_CLEAR = 80_000,
  parameter int T_EN    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_cmd,
  output logic       RS,
  output logic [7:0] DB,
  output logic       EN,
  output logic       ready,
  output logic       pre_ready
);

  localparam int TMAX = (T_CLEAR > T_BYTE) ? T_CLEAR : T_BYTE;
  localparam int CW   = $clog2(TMAX);

  logic          active;
  logic          long_q;
  logic [CW-1:0] bc;
  logic [CW-1:0] last_bc;

  assign last_bc   = long_q ? CW'(T_CLEAR - 1) : CW'(T_BYTE - 1);
  assign ready     = !active || (bc == last_bc);
  // One cycle of warning lets the requester settle rd_data before it is loaded.
  assign pre_ready = active && (bc == last_bc - CW'(1));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      long_q <= 1'b0;
      bc     <= '0;
      RS     <= 1'b0;
      DB     <= 8'h00;
      EN     <= 1'b0;
    end else if (start && ready) begin
      active <= 1'b1;
      long_q <= long_cmd;
      bc     <= '0;
      RS     <= rs;
      DB     <= data;
      EN     <= 1'b0;
    end else if (active) begin
      EN <= (bc < CW'(T_EN));
      if (bc == last_bc) active <= 1'b0;
      else               bc     <= bc + CW'(1);
    end else begin
      EN <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_line_sched.sv
// ST7920 bus owner: power-up wait, init command sequence, then round-robin
// rewriting of whole 16-byte display lines for up to four requesters.
module lcd_line_sched
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 2_000_000,
  parameter int T_BYTE    = 3_600,
  parameter int T_CLEAR   = 80_000,
  parameter int T_EN      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] rd_data,
  output logic [3:0] gnt,
  output logic [3:0] rd_idx,
  output logic [3:0] done,
  output logic       busy,
  output logic       init_done,
  output logic       RS,
  output logic       RW,
  output logic       PSB,
  output logic       EN,
  output logic [7:0] DB
);

  localparam int PW = ($clog2(T_POWERUP + 1) > 5) ? $clog2(T_POWERUP + 1) : 5;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt;
  logic [1:0]    ptr, win, winner;
  logic [3:0]    pend, cand;
  logic          found;
  logic          start, wr_rs, long_cmd, wr_ready, pre_ready;
  logic [7:0]    wr_data;

  assign RW   = 1'b0;
  assign PSB  = 1'b1;
  assign busy = (state_q != ST_IDLE);

  lcd_byte_wr #(.T_BYTE(T_BYTE), .T_CLEAR(T_CLEAR), .T_EN(T_EN)) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_cmd (long_cmd),
    .RS       (RS),
    .DB       (DB),
    .EN       (EN),
    .ready    (wr_ready),
    .pre_ready(pre_ready)
  );

  // Requests seen in IDLE are latched so a one-cycle pulse still wins in ARB.
  always_comb begin
    cand   = pend | req;
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && cand[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
        found  = 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    long_cmd = 1'b0;
    case (state_q)
      ST_PWRUP: if (cnt == PW'(T_POWERUP - 1)) state_d = ST_INIT;
      ST_INIT: begin
        if (wr_ready) begin
          if (cnt == PW'(N_INIT_CMDS)) begin
            state_d = ST_IDLE;
          end else begin
            start    = 1'b1;
            wr_data  = init_cmd(cnt[2:0]);
            long_cmd = (cnt == PW'(CLEAR_CMD_IX));
          end
        end
      end
      ST_IDLE: if (|req) state_d = ST_ARB;
      ST_ARB: begin
        if (found) begin
          start   = 1'b1;
          wr_data = line_addr(winner);
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (wr_ready) begin
          start   = 1'b1;
          wr_rs   = 1'b1;
          wr_data = rd_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wr_ready) begin
          if (cnt == PW'(LINE_BYTES - 1)) begin
            state_d = ST_DONE;
          end else begin
            start   = 1'b1;
            wr_rs   = 1'b1;
            wr_data = rd_data;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PWRUP;
      cnt       <= '0;
      ptr       <= '0;
      win       <= '0;
      pend      <= '0;
      gnt       <= '0;
      done      <= '0;
      rd_idx    <= '0;
      init_done <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= '0;
      case (state_q)
        ST_PWRUP: cnt <= (state_d == ST_INIT) ? '0 : cnt + PW'(1);
        ST_INIT: begin
          if (start) cnt <= cnt + PW'(1);
          if (state_d == ST_IDLE) init_done <= 1'b1;
        end
        ST_IDLE: pend <= req;
        ST_ARB: begin
          pend <= '0;
          if (state_d == ST_ADDR) begin
            gnt <= 4'b0001 << winner;
            win <= winner;
          end
        end
        ST_ADDR: begin
          if (pre_ready) rd_idx <= '0;
          if (start)     cnt    <= '0;
        end
        ST_DATA: begin
          if (pre_ready && cnt != PW'(LINE_BYTES - 1)) rd_idx <= cnt[3:0] + 4'd1;
          if (start) cnt <= cnt + PW'(1);
          if (state_d == ST_DONE) begin
            gnt  <= '0;
            done <= gnt;
          end
        end
        ST_DONE: ptr <= win + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_line_sched.sv
// Directed bench for lcd_line_sched: init sequence, line writes, arbitration,
// dropped requests and mid-line reset, all with hand-computed expectations.
module tb_lcd_line_sched;

  localparam int T_POWERUP = 100;
  localparam int T_BYTE    = 40;
  localparam int T_CLEAR   = 200;
  localparam int T_EN      = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [7:0] rd_data;
  logic [3:0] gnt, rd_idx, done;
  logic       busy, init_done, RS, RW, PSB, EN;
  logic [7:0] DB;
  logic [1:0] gline;

  always #5 clk = ~clk;

  // Requester model: each byte encodes its line and index.
  assign gline   = {gnt[2] | gnt[3], gnt[1] | gnt[3]};
  assign rd_data = {2'b01, gline, rd_idx};

  lcd_line_sched #(
    .T_POWERUP(T_POWERUP), .T_BYTE(T_BYTE), .T_CLEAR(T_CLEAR), .T_EN(T_EN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_data(rd_data), .gnt(gnt),
    .rd_idx(rd_idx), .done(done), .busy(busy), .init_done(init_done),
    .RS(RS), .RW(RW), .PSB(PSB), .EN(EN), .DB(DB)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc;

  logic [8:0] byte_q[$];
  int         en_cyc[$];
  logic [3:0] gnt_list[$];
  int         gnt_rise_cyc, done_cyc, init_cyc;
  int         setup_err = 0;
  int         early_gnt = 0;
  logic [3:0] done_log = 4'b0;
  logic       en_q = 1'b0, rs_q = 1'b0, init_q = 1'b0;
  logic [7:0] db_q = 8'h00;
  logic [3:0] gnt_q = 4'b0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (EN && !en_q) begin
      byte_q.push_back({RS, DB});
      en_cyc.push_back(cyc);
      if (DB !== db_q || RS !== rs_q) setup_err++;
    end
    if (gnt != 4'b0 && gnt_q == 4'b0) begin
      gnt_list.push_back(gnt);
      gnt_rise_cyc = cyc;
    end
    if (done != 4'b0) begin
      done_log = done_log | done;
      done_cyc = cyc;
    end
    if (init_done && !init_q) init_cyc = cyc;
    if (gnt != 4'b0 && !init_done) early_gnt++;
    en_q = EN; db_q = DB; rs_q = RS; gnt_q = gnt; init_q = init_done;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    byte_q.delete();
    en_cyc.delete();
    gnt_list.delete();
  endtask

  function automatic logic [8:0] exp_data(input int line, input int k);
    return {1'b1, 2'b01, 2'(line), 4'(k)};
  endfunction

  task automatic wait_gnt(input string tag, input int budget);
    int n = 0;
    while (gnt == 4'b0 && n < budget) begin tick(); n++; end
    check({tag, " gnt seen"}, 32'(gnt != 4'b0), 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done == 4'b0 && n < budget) begin tick(); n++; end
    check({tag, " done seen"}, 32'(done != 4'b0), 1);
  endtask

  task automatic wait_bytes(input string tag, input int count, input int budget);
    int n = 0;
    while (byte_q.size() < count && n < budget) begin tick(); n++; end
    check({tag, " byte count reached"}, 32'(byte_q.size() >= count), 1);
  endtask

  task automatic check_init(input string tag);
    logic [7:0] cmds [5] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
    int n = 0;
    while (!init_done && n < 1000) begin tick(); n++; end
    check({tag, " init_done cycle"}, init_cyc, 461);
    check({tag, " init byte count"}, byte_q.size(), 5);
    if (byte_q.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        check($sformatf("%s init cmd%0d", tag, i), byte_q[i], {1'b0, cmds[i]});
      check({tag, " first EN cycle"}, en_cyc[0], 102);
      check({tag, " clear gap"}, en_cyc[4] - en_cyc[3], 200);
    end
    clear_logs();
  endtask

  task automatic check_line(input string tag, input int line, input logic [7:0] addr);
    check({tag, " byte count"}, byte_q.size(), 17);
    if (byte_q.size() >= 17) begin
      check({tag, " addr"}, byte_q[0], {1'b0, addr});
      for (int k = 0; k < 16; k++)
        check($sformatf("%s data%0d", tag, k), byte_q[k + 1], exp_data(line, k));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc;
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset values while rst_n is held low.
    #22;
    check("reset EN", EN, 0);
    check("reset DB", DB, 8'h00);
    check("reset RS", RS, 0);
    check("reset gnt", gnt, 0);
    check("reset done", done, 0);
    check("reset rd_idx", rd_idx, 0);
    check("reset busy", busy, 1);
    check("reset init_done", init_done, 0);
    check("RW fixed", RW, 0);
    check("PSB fixed", PSB, 1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();

    // Request during init: held off until init completes.
    while (cyc < 10) tick();
    req = 4'b0001;
    check_init("run1");
    wait_gnt("line0", 100);
    req = 4'b0000;
    check("line0 gnt", gnt, 4'b0001);
    check("line0 gnt cycle", gnt_rise_cyc, 463);
    wait_done("line0", 2000);
    check("line0 done", done, 4'b0001);
    check("line0 duration", done_cyc - gnt_rise_cyc, 680);
    check_line("line0", 0, 8'h80);
    check("no gnt before init_done", early_gnt, 0);
    clear_logs();

    // Drop request mid-DATA: line still completes.
    req = 4'b0010;
    wait_gnt("drop", 100);
    check("drop gnt", gnt, 4'b0010);
    wait_bytes("drop", 6, 2000);
    req = 4'b0000;
    wait_done("drop", 2000);
    check("drop done", done, 4'b0010);
    check_line("drop", 1, 8'h90);
    repeat (3) tick();
    clear_logs();

    // Single-cycle request pulse on line 2.
    check("idle busy", busy, 0);
    req = 4'b0100;
    req_cyc = cyc;
    tick();
    req = 4'b0000;
    wait_gnt("line2", 100);
    check("line2 gnt", gnt, 4'b0100);
    check("line2 arb latency", gnt_rise_cyc - req_cyc, 2);
    wait_done("line2", 2000);
    check("line2 done", done, 4'b0100);
    check("line2 duration", done_cyc - gnt_rise_cyc, 680);
    check_line("line2", 2, 8'h88);
    repeat (3) tick();
    clear_logs();

    // Reset while data byte 7 of line 3 is on the bus.
    done_log = 4'b0;
    req = 4'b1000;
    wait_gnt("rst", 100);
    wait_bytes("rst", 9, 2000);
    check("rst EN high before reset", EN, 1);
    #2;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    check("rst EN forced low", EN, 0);
    check("rst gnt cleared", gnt, 0);
    check("rst init_done cleared", init_done, 0);
    check("rst busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    check_init("run2");
    check("rst no done pulse", done_log, 0);

    // Fairness with all four requests held.
    req = 4'b1111;
    begin
      int n = 0;
      while (gnt_list.size() < 5 && n < 5000) begin tick(); n++; end
    end
    req = 4'b0000;
    check("fair grant count", gnt_list.size(), 5);
    if (gnt_list.size() >= 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("fair grant%0d", i), gnt_list[i], exp_order[i]);

    check("setup DB/RS before EN", setup_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
